// File: rtl/addr_map_cfg.sv
// Address map shadow table, validation sweep and atomic commit to the active map.
// Define ADDR_MAP_CFG_OVERLAP_CHECK_EN to add the pairwise overlap scan.
package addr_map_cfg_pkg;
  typedef logic [31:0] addr_t;
  typedef struct packed {
    int unsigned idx;
    addr_t       start_addr;
    addr_t       end_addr;
  } rule_t;
endpackage

module addr_map_cfg #(
  parameter int unsigned NoIndices = 32'd4,
  parameter int unsigned NoRules   = 32'd4,
  parameter type addr_t = addr_map_cfg_pkg::addr_t,
  parameter type rule_t = addr_map_cfg_pkg::rule_t,
  parameter int unsigned SlotWidth =
    (NoRules > 1) ? $clog2(NoRules) : 1,
  parameter type slot_t = logic [SlotWidth-1:0]
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                wr_valid_i,
  output logic                wr_ready_o,
  input  slot_t               wr_slot_i,
  input  rule_t               wr_rule_i,
  input  logic                commit_valid_i,
  output logic                commit_ready_o,
  output logic                busy_o,
  output logic                commit_done_o,
  output logic                commit_error_o,
  output slot_t               err_slot_o,
  output logic [1:0]          err_code_o,
  output rule_t [NoRules-1:0] addr_map_o,
  output logic                map_valid_o
);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
`ifdef ADDR_MAP_CFG_OVERLAP_CHECK_EN
    PAIR,
`endif
    DONE,
    ERR
  } state_e;

  localparam slot_t LastSlot = slot_t'(NoRules - 1);

  state_e state_q, state_d;
  slot_t  i_q, i_d;
  slot_t  err_slot_q, err_slot_d;
  logic [1:0] err_code_q, err_code_d;
  rule_t [NoRules-1:0] shadow_q;
  rule_t cur;
`ifdef ADDR_MAP_CFG_OVERLAP_CHECK_EN
  slot_t j_q, j_d;
  rule_t oth;
`endif

  assign wr_ready_o     = (state_q == IDLE);
  assign commit_ready_o = (state_q == IDLE);
  assign commit_done_o  = (state_q == DONE);
  assign commit_error_o = (state_q == ERR);
  assign err_slot_o     = err_slot_q;
  assign err_code_o     = err_code_q;
`ifdef ADDR_MAP_CFG_OVERLAP_CHECK_EN
  assign busy_o = (state_q == CHECK) || (state_q == PAIR);
`else
  assign busy_o = (state_q == CHECK);
`endif

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    err_slot_d = err_slot_q;
    err_code_d = err_code_q;
    cur        = shadow_q[i_q];
`ifdef ADDR_MAP_CFG_OVERLAP_CHECK_EN
    j_d = j_q;
    oth = shadow_q[j_q];
`endif
    unique case (state_q)
      IDLE: begin
        if (commit_valid_i) begin
          state_d    = CHECK;
          i_d        = '0;
          err_slot_d = '0;
          err_code_d = 2'd0;
        end
      end
      CHECK: begin
        // range error outranks index error within one slot
        if (cur.start_addr >= cur.end_addr) begin
          state_d    = ERR;
          err_slot_d = i_q;
          err_code_d = 2'd1;
        end else if (cur.idx >= NoIndices) begin
          state_d    = ERR;
          err_slot_d = i_q;
          err_code_d = 2'd2;
        end else if (i_q == LastSlot) begin
`ifdef ADDR_MAP_CFG_OVERLAP_CHECK_EN
          if (NoRules > 1) begin
            state_d = PAIR;
            i_d     = '0;
            j_d     = slot_t'(1);
          end else begin
            state_d = DONE;
          end
`else
          state_d = DONE;
`endif
        end else begin
          i_d = i_q + slot_t'(1);
        end
      end
`ifdef ADDR_MAP_CFG_OVERLAP_CHECK_EN
      PAIR: begin
        if (oth.start_addr < cur.end_addr &&
            oth.end_addr > cur.start_addr) begin
          state_d    = ERR;
          err_slot_d = j_q;
          err_code_d = 2'd3;
        end else if (j_q == LastSlot) begin
          if (i_q == LastSlot - slot_t'(1)) begin
            state_d = DONE;
          end else begin
            i_d = i_q + slot_t'(1);
            j_d = i_q + slot_t'(2);
          end
        end else begin
          j_d = j_q + slot_t'(1);
        end
      end
`endif
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      i_q         <= '0;
      err_slot_q  <= '0;
      err_code_q  <= 2'd0;
      shadow_q    <= '0;
      addr_map_o  <= '0;
      map_valid_o <= 1'b0;
`ifdef ADDR_MAP_CFG_OVERLAP_CHECK_EN
      j_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      err_slot_q <= err_slot_d;
      err_code_q <= err_code_d;
`ifdef ADDR_MAP_CFG_OVERLAP_CHECK_EN
      j_q <= j_d;
`endif
      // out-of-range slots are accepted but dropped
      if (wr_valid_i && wr_ready_o &&
          32'(wr_slot_i) < NoRules) begin
        shadow_q[wr_slot_i] <= wr_rule_i;
      end
      if (state_q == DONE) begin
        addr_map_o  <= shadow_q;
        map_valid_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_addr_map_cfg.sv
// Scoreboard bench for addr_map_cfg: model predicts each commit outcome,
// monitor pops and compares on every done/error pulse.
module tb_addr_map_cfg;
  import addr_map_cfg_pkg::*;

  localparam int NR = 4;
  localparam int NI = 4;
  typedef rule_t [NR-1:0] map_t;
  typedef struct {
    bit     err;
    int     slot;
    int     code;
    longint due;
    map_t   map;
    bit     mv;
  } exp_t;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       wr_valid_i = 1'b0;
  logic       wr_ready_o;
  logic [1:0] wr_slot_i = '0;
  rule_t      wr_rule_i = '0;
  logic       commit_valid_i = 1'b0;
  logic       commit_ready_o;
  logic       busy_o;
  logic       commit_done_o;
  logic       commit_error_o;
  logic [1:0] err_slot_o;
  logic [1:0] err_code_o;
  map_t       addr_map_o;
  logic       map_valid_o;

  addr_map_cfg dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .wr_valid_i     (wr_valid_i),
    .wr_ready_o     (wr_ready_o),
    .wr_slot_i      (wr_slot_i),
    .wr_rule_i      (wr_rule_i),
    .commit_valid_i (commit_valid_i),
    .commit_ready_o (commit_ready_o),
    .busy_o         (busy_o),
    .commit_done_o  (commit_done_o),
    .commit_error_o (commit_error_o),
    .err_slot_o     (err_slot_o),
    .err_code_o     (err_code_o),
    .addr_map_o     (addr_map_o),
    .map_valid_o    (map_valid_o)
  );

  always #5 clk_i = ~clk_i;

  longint cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  map_t sh_m = '0;
  map_t act_m = '0;
  bit   mv_m = 1'b0;
  int   last_code = 0;

  task automatic check(string tag, logic [511:0] got,
                       logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic rule_t mk(int unsigned idx, logic [31:0] s,
                               logic [31:0] e);
    rule_t r;
    r.idx        = idx;
    r.start_addr = s;
    r.end_addr   = e;
    return r;
  endfunction

  // Independent model of the sweep: outcome and pulse cycle
  function automatic void predict(output bit err, output int slot,
                                  output int code, output int lat);
    err = 0; slot = 0; code = 0;
    for (int s = 0; s < NR; s++) begin
      if (!(sh_m[s].start_addr < sh_m[s].end_addr)) begin
        err = 1; slot = s; code = 1; lat = s + 2;
        return;
      end
      if (sh_m[s].idx >= NI) begin
        err = 1; slot = s; code = 2; lat = s + 2;
        return;
      end
    end
    lat = NR + 1;
`ifdef ADDR_MAP_CFG_OVERLAP_CHECK_EN
    begin
      int p;
      p = 0;
      for (int a = 0; a < NR; a++)
        for (int b = a + 1; b < NR; b++) begin
          if (sh_m[b].start_addr < sh_m[a].end_addr &&
              sh_m[b].end_addr > sh_m[a].start_addr) begin
            err = 1; slot = b; code = 3; lat = NR + 2 + p;
            return;
          end
          p++;
        end
      lat = NR + 1 + p;
    end
`endif
  endfunction

  always @(negedge clk_i) begin : mon
    exp_t e;
    if (rst_ni && (commit_done_o || commit_error_o)) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", 1, 0);
      end else begin
        e = sb.pop_front();
        check("err_pulse", commit_error_o, e.err);
        check("done_pulse", commit_done_o, !e.err);
        check("pulse_cycle", cyc, e.due);
        check("err_slot", err_slot_o, e.slot);
        check("err_code", err_code_o, e.code);
        @(posedge clk_i);
        #1;
        check("addr_map", addr_map_o, e.map);
        check("map_valid", map_valid_o, e.mv);
      end
    end
  end

  task automatic do_write(int slot, rule_t r, output int stalls);
    @(negedge clk_i);
    wr_valid_i = 1'b1;
    wr_slot_i  = 2'(slot);
    wr_rule_i  = r;
    stalls = 0;
    while (!wr_ready_o && stalls < 200) begin
      if (stalls == 0) check("busy_while_stalled", busy_o, 1);
      @(negedge clk_i);
      stalls++;
    end
    if (stalls >= 200) begin
      check("write_timeout", 0, 1);
    end else begin
      @(posedge clk_i);
      if (slot < NR) sh_m[slot] = r;
    end
    #1 wr_valid_i = 1'b0;
  endtask

  task automatic do_commit(bit with_wr, int slot, rule_t r);
    bit   err;
    int   es, ec, lat, n;
    exp_t e;
    @(negedge clk_i);
    commit_valid_i = 1'b1;
    wr_valid_i     = with_wr;
    wr_slot_i      = 2'(slot);
    wr_rule_i      = r;
    n = 0;
    while (!commit_ready_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 200) begin
      check("commit_timeout", 0, 1);
    end else begin
      if (with_wr && slot < NR) sh_m[slot] = r;
      predict(err, es, ec, lat);
      if (!err) begin
        act_m = sh_m;
        mv_m  = 1'b1;
      end
      e.err = err; e.slot = es; e.code = ec;
      e.due = cyc + longint'(lat);
      e.map = act_m; e.mv = mv_m;
      last_code = ec;
      sb.push_back(e);
      @(posedge clk_i);
    end
    #1;
    commit_valid_i = 1'b0;
    wr_valid_i     = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || !commit_ready_o) && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 200) check("idle_timeout", 0, 1);
    repeat (2) @(negedge clk_i);
  endtask

  task automatic load_base();
    int st;
    for (int s = 0; s < NR; s++)
      do_write(s, mk(s, 32'h1000 * s, 32'h1000 * s + 32'h1000), st);
  endtask

  initial begin
    int st;
    repeat (2) @(negedge clk_i);
    check("rst_wr_ready", wr_ready_o, 1);
    check("rst_commit_ready", commit_ready_o, 1);
    check("rst_busy", busy_o, 0);
    check("rst_done", commit_done_o, 0);
    check("rst_error", commit_error_o, 0);
    check("rst_err_slot", err_slot_o, 0);
    check("rst_err_code", err_code_o, 0);
    check("rst_map_valid", map_valid_o, 0);
    check("rst_map", addr_map_o, 0);
    rst_ni = 1'b1;

    // all-zero shadow fails slot 0 with range error
    do_commit(0, 0, '0);
    wait_idle();

    // valid base map commits
    load_base();
    do_commit(0, 0, '0);
    wait_idle();
    check("code_after_done", err_code_o, last_code);

    // bad index on slot 2, active map must survive
    do_write(2, mk(4, 32'h2000, 32'h3000), st);
    do_commit(0, 0, '0);
    wait_idle();
    repeat (3) @(negedge clk_i);
    check("err_code_held", err_code_o, last_code);
    check("err_slot_held", err_slot_o, 2);
    do_write(2, mk(2, 32'h2000, 32'h3000), st);

    // empty range plus bad index: range error wins
    do_write(1, mk(7, 32'h5000, 32'h5000), st);
    do_commit(0, 0, '0);
    wait_idle();
    do_write(1, mk(1, 32'h1000, 32'h2000), st);

    // boundary: top of address space, highest legal index
    do_write(3, mk(NI - 1, 32'hFFFF_FFFE, 32'hFFFF_FFFF), st);
    do_commit(0, 0, '0);
    wait_idle();

    // same-cycle write+commit, then a write stalled by the sweep
    do_commit(1, 3, mk(3, 32'h9000, 32'h8000));
    do_write(3, mk(3, 32'h3000, 32'h4000), st);
    check("write_stalled", st > 0, 1);
    wait_idle();
    do_commit(0, 0, '0);
    wait_idle();

    // overlapping slots 0 and 1
    do_write(0, mk(0, 32'h1000, 32'h2000), st);
    do_write(1, mk(1, 32'h1800, 32'h2800), st);
    do_commit(0, 0, '0);
    wait_idle();
    load_base();

    // reset in the middle of a sweep
    do_commit(0, 0, '0);
    @(negedge clk_i);
    @(negedge clk_i);
    check("busy_mid_sweep", busy_o, 1);
    #2 rst_ni = 1'b0;
    sb.delete();
    sh_m  = '0;
    act_m = '0;
    mv_m  = 1'b0;
    #1;
    check("async_busy", busy_o, 0);
    check("async_map", addr_map_o, 0);
    check("async_map_valid", map_valid_o, 0);
    check("async_err_code", err_code_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("post_rst_wr_ready", wr_ready_o, 1);

    // shadow was cleared too
    do_commit(0, 0, '0);
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
